// File: rtl/note_sequencer.sv
// note_sequencer: plays one of four ROM songs as a stream of 4-bit note codes.
// Each note is a FETCH cycle, dur*TICK_DIV-GAP_CYC PLAY cycles and GAP_CYC
// silent GAP cycles. Supports start (edge), stop (abort) and pause (freeze).
// Optional build macro NOTE_SEQ_LOOP_EN: when defined the song repeats from
// index 0 after every end-of-song instead of returning to IDLE.
module note_sequencer #(
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned GAP_CYC  = 25000,
    parameter int unsigned ADDR_W   = 6,
    parameter logic [3:0]  REST     = 4'd14
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [1:0]        song_sel,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [3:0]        notes,
    output logic              note_valid,
    output logic              beat,
    output logic [ADDR_W-1:0] idx,
    output logic              playing,
    output logic              done
);

    localparam int unsigned       CNT_W    = $clog2(15 * TICK_DIV + 1);
    localparam logic [CNT_W-1:0]  TICK_CNT = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0]  GAP_CNT  = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] IDX_ZERO = '0;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

`ifdef NOTE_SEQ_LOOP_EN
    localparam logic PLAY_IN_END = 1'b1;
`else
    localparam logic PLAY_IN_END = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_END
    } state_t;

    state_t            state;
    logic [1:0]        song_q;
    logic [1:0]        sel_q;
    logic [7:0]        rom_q;
    logic [CNT_W-1:0]  cnt;
    logic              start_d;
    logic              start_rise_q;

    // Song ROM: entry = {note[3:0], dur[3:0]}; dur==0 terminates the song.
    function automatic logic [7:0] rom_entry(input logic [1:0] song,
                                             input logic [ADDR_W-1:0] addr);
        logic [7:0]  e;
        int unsigned ai;
        ai = 32'(addr);
        e  = 8'h00;
        unique case (song)
            2'd0: begin
                case (ai)
                    0:  e = 8'h52;
                    1:  e = 8'h52;
                    2:  e = 8'h62;
                    3:  e = 8'h74;
                    4:  e = 8'h72;
                    5:  e = 8'h62;
                    6:  e = 8'h54;
                    7:  e = 8'h42;
                    8:  e = 8'h42;
                    9:  e = 8'h52;
                    10: e = 8'h64;
                    11: e = 8'h56;
                    default: e = 8'h00;
                endcase
            end
            2'd1: begin
                case (ai)
                    0:  e = 8'h81;
                    1:  e = 8'h91;
                    2:  e = 8'hA2;
                    3:  e = 8'h91;
                    4:  e = 8'h81;
                    5:  e = 8'h72;
                    6:  e = 8'h81;
                    7:  e = 8'h91;
                    8:  e = 8'hA1;
                    9:  e = 8'hB1;
                    10: e = 8'hC2;
                    11: e = 8'hB1;
                    12: e = 8'hA1;
                    13: e = 8'h94;
                    default: e = 8'h00;
                endcase
            end
            2'd2: begin
                case (ai)
                    0:  e = 8'h33;
                    1:  e = 8'h41;
                    2:  e = 8'h52;
                    3:  e = 8'h33;
                    4:  e = 8'h41;
                    5:  e = 8'h52;
                    6:  e = 8'h62;
                    7:  e = 8'h72;
                    8:  e = 8'h84;
                    9:  e = 8'h62;
                    10: e = 8'h52;
                    11: e = 8'h44;
                    12: e = 8'h38;
                    default: e = 8'h00;
                endcase
            end
            default: begin
                case (ai)
                    0:  e = 8'h11;
                    1:  e = 8'h22;
                    2:  e = 8'h31;
                    default: e = 8'h00;
                endcase
            end
        endcase
        return e;
    endfunction

    // Start rising-edge detector; a start coincident with stop is dropped.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            start_d      <= 1'b0;
            start_rise_q <= 1'b0;
            sel_q        <= 2'd0;
        end else begin
            start_d      <= start;
            start_rise_q <= start & ~start_d & ~stop;
            if (start && !start_d) begin
                sel_q <= song_sel;
            end
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state      <= S_IDLE;
            song_q     <= 2'd0;
            rom_q      <= 8'h00;
            cnt        <= '0;
            idx        <= IDX_ZERO;
            notes      <= REST;
            note_valid <= 1'b0;
            beat       <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else if (stop && state != S_IDLE) begin
            state      <= S_IDLE;
            rom_q      <= 8'h00;
            cnt        <= '0;
            idx        <= IDX_ZERO;
            notes      <= REST;
            note_valid <= 1'b0;
            beat       <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            beat <= 1'b0;
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    notes      <= REST;
                    note_valid <= 1'b0;
                    playing    <= 1'b0;
                    if (start_rise_q && !stop) begin
                        song_q  <= sel_q;
                        idx     <= IDX_ZERO;
                        rom_q   <= rom_entry(sel_q, IDX_ZERO);
                        playing <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (rom_q[3:0] == 4'd0) begin
                        state      <= S_END;
                        idx        <= IDX_ZERO;
                        notes      <= REST;
                        note_valid <= 1'b0;
                        done       <= 1'b1;
                        playing    <= PLAY_IN_END;
                    end else begin
                        state      <= S_PLAY;
                        cnt        <= CNT_W'(rom_q[3:0]) * TICK_CNT - GAP_CNT;
                        notes      <= rom_q[7:4];
                        note_valid <= 1'b1;
                        beat       <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        notes      <= REST;
                        note_valid <= 1'b0;
                    end else if (cnt == CNT_ONE) begin
                        state      <= S_GAP;
                        cnt        <= GAP_CNT;
                        notes      <= REST;
                        note_valid <= 1'b0;
                    end else begin
                        cnt        <= cnt - CNT_ONE;
                        notes      <= rom_q[7:4];
                        note_valid <= 1'b1;
                    end
                end
                S_GAP: begin
                    notes      <= REST;
                    note_valid <= 1'b0;
                    if (!pause) begin
                        if (cnt != CNT_ONE) begin
                            cnt <= cnt - CNT_ONE;
                        end else if (idx == LAST_IDX) begin
                            // Ran off the end of the ROM without a terminator.
                            state   <= S_END;
                            idx     <= IDX_ZERO;
                            done    <= 1'b1;
                            playing <= PLAY_IN_END;
                        end else begin
                            state <= S_FETCH;
                            idx   <= idx + IDX_ONE;
                            rom_q <= rom_entry(song_q, idx + IDX_ONE);
                        end
                    end
                end
                S_END: begin
                    notes      <= REST;
                    note_valid <= 1'b0;
                    idx        <= IDX_ZERO;
`ifdef NOTE_SEQ_LOOP_EN
                    state      <= S_FETCH;
                    rom_q      <= rom_entry(song_q, IDX_ZERO);
                    playing    <= 1'b1;
`else
                    state      <= S_IDLE;
                    playing    <= 1'b0;
`endif
                end
                default: begin
                    state      <= S_IDLE;
                    notes      <= REST;
                    note_valid <= 1'b0;
                    playing    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer using test song 3 with TICK_DIV=10, GAP_CYC=2.
module tb_note_sequencer;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned GAP_CYC  = 2;
    localparam int unsigned ADDR_W   = 6;
`ifdef NOTE_SEQ_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESETN;
    logic [1:0]        song_sel;
    logic              start;
    logic              stop;
    logic              pause;
    logic [3:0]        notes;
    logic              note_valid;
    logic              beat;
    logic [ADDR_W-1:0] idx;
    logic              playing;
    logic              done;

    note_sequencer #(
        .TICK_DIV(TICK_DIV),
        .GAP_CYC (GAP_CYC),
        .ADDR_W  (ADDR_W),
        .REST    (4'd14)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .song_sel  (song_sel),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .notes     (notes),
        .note_valid(note_valid),
        .beat      (beat),
        .idx       (idx),
        .playing   (playing),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int off      = 0;
    int w_c1, w_c2, w_c3, w_nb, w_nd, w_doff, w_dplay, w_nv, w_r1, w_bfirst, w_bnote;
    int q_nb, q_nd, q_np;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        off++;
    endtask

    // Start edge sampled at offset 0, then step to offset 1 (FETCH).
    task automatic begin_song();
        off   = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    // Observe up to offset 'last', collecting statistics and applying pokes.
    task automatic run_window(input int last, input int p_on, input int p_off,
                              input int r_on, input int r_off);
        w_c1 = 0; w_c2 = 0; w_c3 = 0; w_nb = 0; w_nd = 0; w_doff = -1;
        w_dplay = -1; w_nv = 0; w_r1 = 0; w_bfirst = -1; w_bnote = -1;
        while (off < last) begin
            tick();
            if (notes == 4'd1) w_c1++;
            if (notes == 4'd2) w_c2++;
            if (notes == 4'd3) w_c3++;
            if (note_valid) w_nv++;
            if (idx == 6'd1 && notes == 4'd14) w_r1++;
            if (beat) begin
                w_nb++;
                if (w_bfirst < 0) begin
                    w_bfirst = off;
                    w_bnote  = 32'(notes);
                end
            end
            if (done) begin
                w_nd++;
                w_doff  = off;
                w_dplay = 32'(playing);
            end
            if (off == p_on)  pause = 1'b1;
            if (off == p_off) pause = 1'b0;
            if (off == r_on)  begin start = 1'b1; song_sel = 2'd0; end
            if (off == r_off) begin start = 1'b0; song_sel = 2'd3; end
        end
    endtask

    initial begin
        RESETN   = 1'b0;
        song_sel = 2'd3;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_notes", 32'(notes), 14);
        check("rst_idx", 32'(idx), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_beat", 32'(beat), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(note_valid), 0);
        RESETN = 1'b1;
        tick();
        tick();

        // Full song
        begin_song();
        check("s2_fetch_playing", 32'(playing), 1);
        check("s2_fetch_beat", 32'(beat), 0);
        check("s2_fetch_notes", 32'(notes), 14);
        check("s2_fetch_idx", 32'(idx), 0);
        run_window(45, -1, -1, -1, -1);
        check("s2_first_beat_off", 32'(w_bfirst), 2);
        check("s2_first_beat_note", 32'(w_bnote), 1);
        check("s2_note1_cycles", 32'(w_c1), 8);
        check("s2_note2_cycles", 32'(w_c2), 18);
        check("s2_note3_cycles", 32'(w_c3), 8);
        check("s2_valid_cycles", 32'(w_nv), 34);
        check("s2_rest_idx1", 32'(w_r1), 3);
        check("s2_beats", 32'(w_nb), 3);
        check("s2_dones", 32'(w_nd), 1);
        check("s2_done_off", 32'(w_doff), 45);
        check("s2_done_playing", 32'(w_dplay), 32'(LOOP));
`ifdef NOTE_SEQ_LOOP_EN
        // Loop: song restarts from entry 0
        tick();
        check("lp_fetch_playing", 32'(playing), 1);
        check("lp_fetch_idx", 32'(idx), 0);
        check("lp_fetch_done", 32'(done), 0);
        tick();
        check("lp_beat", 32'(beat), 1);
        check("lp_notes", 32'(notes), 1);
        check("lp_idx", 32'(idx), 0);
        check("lp_playing", 32'(playing), 1);
`else
        tick();
        check("s2_end_playing", 32'(playing), 0);
        check("s2_end_notes", 32'(notes), 14);
        check("s2_end_idx", 32'(idx), 0);
        check("s2_end_done", 32'(done), 0);
`endif
        stop_pulse();
        check("s2_idle_playing", 32'(playing), 0);

        // Pause for 5 cycles in the middle of note 2
        begin_song();
        run_window(50, 20, 25, -1, -1);
        check("s3_note1_cycles", 32'(w_c1), 8);
        check("s3_note2_cycles", 32'(w_c2), 18);
        check("s3_note3_cycles", 32'(w_c3), 8);
        check("s3_valid_cycles", 32'(w_nv), 34);
        check("s3_rest_idx1", 32'(w_r1), 8);
        check("s3_beats", 32'(w_nb), 3);
        check("s3_dones", 32'(w_nd), 1);
        check("s3_done_off", 32'(w_doff), 50);
        stop_pulse();

        // Stop and start together while playing
        begin_song();
        for (int i = 0; i < 14; i++) tick();
        check("s4_pre_notes", 32'(notes), 2);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        check("s4_playing", 32'(playing), 0);
        check("s4_notes", 32'(notes), 14);
        check("s4_idx", 32'(idx), 0);
        check("s4_valid", 32'(note_valid), 0);
        check("s4_done", 32'(done), 0);
        stop = 1'b0;
        q_nb = 0; q_nd = 0; q_np = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (beat)    q_nb++;
            if (done)    q_nd++;
            if (playing) q_np++;
        end
        check("s4_no_beat", 32'(q_nb), 0);
        check("s4_no_done", 32'(q_nd), 0);
        check("s4_no_restart", 32'(q_np), 0);
        start = 1'b0;
        tick();

        // Retrigger and song change during PLAY are ignored
        song_sel = 2'd3;
        begin_song();
        run_window(45, -1, -1, 5, 7);
        check("s5_note1_cycles", 32'(w_c1), 8);
        check("s5_note2_cycles", 32'(w_c2), 18);
        check("s5_note3_cycles", 32'(w_c3), 8);
        check("s5_rest_idx1", 32'(w_r1), 3);
        check("s5_beats", 32'(w_nb), 3);
        check("s5_done_off", 32'(w_doff), 45);
        stop_pulse();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
